truth_table_sweeper: RTL

//   Sequencer and self-checker for an N_IN-input combinational function block.
//   On start it drives every input combination (0..2^N_IN-1) into the function,

---
 rtl/truth_table_sweeper_if.sv | 28 ++
 rtl/truth_table_sweeper.sv | 105 ++++++++++
 2 files changed

// File: rtl/truth_table_sweeper_if.sv
// Bus between the truth-table sweeper and its controller / function under sweep.
interface truth_table_sweeper_if #(
  parameter int N_IN = 4
);
  localparam int DEPTH = 1 << N_IN;

  logic              start;
  logic [DEPTH-1:0]  expected;
  logic              f_in;
  logic [N_IN-1:0]   dut_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic [DEPTH-1:0]  captured;
  logic [N_IN:0]     mismatch_count;
  logic              fail_valid;
  logic [N_IN-1:0]   first_fail_idx;

  modport master (
    output start, expected, f_in,
    input  dut_in, busy, done, pass, captured, mismatch_count, fail_valid, first_fail_idx
  );

  modport slave (
    input  start, expected, f_in,
    output dut_in, busy, done, pass, captured, mismatch_count, fail_valid, first_fail_idx
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive sweep of an N_IN-input combinational function: apply, settle, sample,
// and compare each vector against a golden table latched at start.
module truth_table_sweeper #(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_sweeper_if.slave  bus
);
  localparam int DEPTH = 1 << N_IN;
  localparam int CW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;
  localparam logic [N_IN-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;

  state_t            r_state, w_next;
  logic [DEPTH-1:0]  r_exp;
  logic [N_IN-1:0]   r_idx;
  logic [CW-1:0]     r_cnt;
  logic [N_IN-1:0]   r_dut_in;
  logic [DEPTH-1:0]  r_captured;
  logic [N_IN:0]     r_mcnt;
  logic              r_fail_valid;
  logic [N_IN-1:0]   r_first;
  logic              r_pass;
  logic              w_mis;
  logic [N_IN:0]     w_mcnt_next;

  assign w_mis       = bus.f_in != r_exp[r_idx];
  assign w_mcnt_next = r_mcnt + (N_IN+1)'(w_mis);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = APPLY;
      APPLY:   w_next = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      SETTLE:  if (r_cnt == CNT_LAST) w_next = SAMPLE;
      SAMPLE:  w_next = (r_idx == IDX_LAST) ? DONE : APPLY;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // dut_in is loaded on entry to APPLY, so each vector is stable for the
  // whole APPLY/SETTLE/SAMPLE window and holds the last vector after DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp        <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_dut_in     <= '0;
      r_captured   <= '0;
      r_mcnt       <= '0;
      r_fail_valid <= 1'b0;
      r_first      <= '0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_exp        <= bus.expected;
          r_captured   <= '0;
          r_mcnt       <= '0;
          r_fail_valid <= 1'b0;
          r_first      <= '0;
          r_pass       <= 1'b0;
          r_idx        <= '0;
          r_dut_in     <= '0;
        end
        APPLY:  r_cnt <= '0;
        SETTLE: r_cnt <= r_cnt + CW'(1);
        SAMPLE: begin
          r_captured[r_idx] <= bus.f_in;
          r_mcnt            <= w_mcnt_next;
          if (w_mis && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_first      <= r_idx;
          end
          if (r_idx == IDX_LAST) begin
            r_pass <= (w_mcnt_next == '0);
          end else begin
            r_idx    <= r_idx + N_IN'(1);
            r_dut_in <= r_idx + N_IN'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dut_in         = r_dut_in;
  assign bus.busy           = (r_state != IDLE);
  assign bus.done           = (r_state == DONE);
  assign bus.pass           = r_pass;
  assign bus.captured       = r_captured;
  assign bus.mismatch_count = r_mcnt;
  assign bus.fail_valid     = r_fail_valid;
  assign bus.first_fail_idx = r_first;
endmodule
